// File: rtl/if_fetch_queue.sv
// Instruction fetch initiator: owns the PC, drives the ROM port
// and queues {pc, inst} pairs for decode behind a valid/ready handshake.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic          ce_q;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic full, pop, push;

  assign full = (cnt_q == CW'(DEPTH));
  assign pop  = id_valid & id_ready;
  assign push = ce_q & ~redirect_i & (~full | pop);

  assign rom_ce   = ce_q;
  assign rom_addr = pc_q;

  assign id_valid = (cnt_q != '0);
  assign id_pc    = id_valid ? pc_mem[rd_q]   : 32'h0;
  assign id_inst  = id_valid ? inst_mem[rd_q] : 32'h0;

  always_comb begin
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redirect_i) begin
      // Flush beats everything queued or in flight
      pc_d  = redirect_pc_i & ~32'h3;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ce_q  <= 1'b0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ce_q  <= 1'b1;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[wr_q]   <= pc_q;
      inst_mem[wr_q] <= rom_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue; ROM model returns (addr>>2)+0x100.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_inst = (rom_addr >> 2) + 32'h100;

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .rom_ce(rom_ce),
    .rom_addr(rom_addr),
    .rom_inst(rom_inst),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_pc(id_pc),
    .id_inst(id_inst)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT one cycle after reset release: rom_ce=1, pc=0, empty
  task automatic do_reset();
    rst = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    id_ready = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    step();
    step();
    checks++;
    if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || id_valid !== 1'b0
        || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset ce=%b addr=%h v=%b pc=%h inst=%h want 0,0,0,0,0",
               rom_ce, rom_addr, id_valid, id_pc, id_inst);
    end
    rst = 1'b1;
    step();
    checks++;
    if (rom_ce !== 1'b1 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL release ce=%b v=%b want ce=1 v=0", rom_ce, id_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)
          || id_inst !== 32'(32'h100 + i)) begin
        errors++;
        $display("FAIL stream%0d v=%b pc=%h inst=%h want 1 %h %h", i,
                 id_valid, id_pc, id_inst, 32'(4 * i), 32'(32'h100 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (rom_addr !== 32'h10 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_stall addr=%h v=%b pc=%h want 10 1 0",
               rom_addr, id_valid, id_pc);
    end
    id_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)
          || id_inst !== 32'(32'h100 + i)) begin
        errors++;
        $display("FAIL bp_drain%0d v=%b pc=%h inst=%h want 1 %h %h", i,
                 id_valid, id_pc, id_inst, 32'(4 * i), 32'(32'h100 + i));
      end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (rom_addr !== 32'h10) begin
      errors++;
      $display("FAIL fill addr=%h want 10", rom_addr);
    end
    id_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if (rom_addr !== 32'(32'h10 + 4 * i) || id_pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL fullpp%0d addr=%h pc=%h want %h %h", i, rom_addr,
                 id_pc, 32'(32'h10 + 4 * i), 32'(4 * i));
      end
    end
    id_ready = 1'b0;
    step();
    step();
    checks++;
    if (rom_addr !== 32'h1C || id_pc !== 32'hC) begin
      errors++;
      $display("FAIL still_full addr=%h pc=%h want 1c c", rom_addr, id_pc);
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (rom_addr !== 32'h20 || id_pc !== 32'h10 || id_inst !== 32'h104) begin
      errors++;
      $display("FAIL full_resume addr=%h pc=%h inst=%h want 20 10 104",
               rom_addr, id_pc, id_inst);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (rom_addr !== 32'hC || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL rd_pre addr=%h pc=%h want c 0", rom_addr, id_pc);
    end
    id_ready = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h203;
    step();
    redirect_i = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || rom_addr !== 32'h200 || rom_ce !== 1'b1) begin
      errors++;
      $display("FAIL rd_flush v=%b addr=%h ce=%b want 0 200 1",
               id_valid, rom_addr, rom_ce);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== 32'h180) begin
      errors++;
      $display("FAIL rd_target v=%b pc=%h inst=%h want 1 200 180",
               id_valid, id_pc, id_inst);
    end
    step();
    checks++;
    if (id_pc !== 32'h204 || id_inst !== 32'h181) begin
      errors++;
      $display("FAIL rd_next pc=%h inst=%h want 204 181", id_pc, id_inst);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
    exp_in = '{32'h400000FE, 32'h400000FF, 32'h100, 32'h101};
    do_reset();
    id_ready = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFFFFF8;
    step();
    redirect_i = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || rom_addr !== 32'hFFFFFFF8) begin
      errors++;
      $display("FAIL wrap_flush v=%b addr=%h want 0 fffffff8",
               id_valid, rom_addr);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc[i]
          || id_inst !== exp_in[i]) begin
        errors++;
        $display("FAIL wrap%0d v=%b pc=%h inst=%h want 1 %h %h", i,
                 id_valid, id_pc, id_inst, exp_pc[i], exp_in[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    id_ready = 1'b0;
    step();
    step();
    checks++;
    if (rom_addr !== 32'h8 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL mr_pre addr=%h pc=%h v=%b want 8 0 1",
               rom_addr, id_pc, id_valid);
    end
    rst = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    step();
    checks++;
    if (id_valid !== 1'b0 || rom_ce !== 1'b0 || rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL mr_reset v=%b ce=%b addr=%h want 0 0 0",
               id_valid, rom_ce, rom_addr);
    end
    rst = 1'b1;
    redirect_i = 1'b0;
    id_ready = 1'b1;
    step();
    checks++;
    if (rom_ce !== 1'b1 || id_valid !== 1'b0 || rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL mr_dead ce=%b v=%b addr=%h want 1 0 0",
               rom_ce, id_valid, rom_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)
          || id_inst !== 32'(32'h100 + i)) begin
        errors++;
        $display("FAIL mr_restart%0d v=%b pc=%h inst=%h want 1 %h %h", i,
                 id_valid, id_pc, id_inst, 32'(4 * i), 32'(32'h100 + i));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    id_ready = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_redirect();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
